rr_gate_arbiter: RTL and testbench

//   Round-robin arbiter that shares one gate-level resource (a shared OR/AND/XOR

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 34 +++
 rtl/rr_gate_arbiter.sv | 118 +++++++++++
 tb/tb_rr_gate_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and width helpers for the round-robin gate arbiter
package arb_pkg;

    localparam int MAX_N = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Hold-counter width able to represent 0 .. max_hold-1.
    function automatic int hcw_of(input int max_hold);
        return (max_hold <= 2) ? 1 : $clog2(max_hold);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker starting at ptr_i
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] pick_o,
    output logic           any_o
);

    int             idx;
    logic [IDW-1:0] idx_w;

    // Walk offsets from farthest to nearest so the request closest to ptr_i wins.
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = IDW'(idx);
            if (req_i[idx_w]) begin
                pick_o = idx_w;
                any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_gate_arbiter.sv
// rtl/rr_gate_arbiter.sv - round-robin owner arbiter for the shared gate unit (optional ARB_LOCK_EN)
module rr_gate_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic [N-1:0]   req_i,
    input  logic           done_i,
    input  logic           lock_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic           busy_o,
    output logic           timeout_o
);

    localparam int HCW = hcw_of(MAX_HOLD);
    localparam logic [HCW-1:0] HCNT_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] pick;
    logic           any;
    logic           owner_req;
    logic           hold_freeze;
    logic           hold_tmo;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any)
    );

`ifdef ARB_LOCK_EN
    assign hold_freeze = lock_i;
`else
    logic unused_lock;
    assign unused_lock = lock_i;
    assign hold_freeze = 1'b0;
`endif

    assign owner_req = req_i[gnt_id_q];
    assign hold_tmo  = (hcnt_q == HCNT_LAST) && !hold_freeze;

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_id_q  <= '0;
            gnt_q     <= '0;
            hcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_id_q  <= gnt_id_d;
            gnt_q     <= gnt_d;
            hcnt_q    <= hcnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Grant in IDLE, release on done/request drop/timeout in OWN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_id_d  = gnt_id_q;
        gnt_d     = gnt_q;
        hcnt_d    = hcnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d  = OWN;
                    gnt_d    = N'(1) << pick;
                    gnt_id_d = pick;
                    hcnt_d   = '0;
                end
            end
            OWN: begin
                if (done_i || !owner_req || hold_tmo) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    hcnt_d    = '0;
                    ptr_d     = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + 1'b1;
                    // A coinciding done or request drop makes this a normal release.
                    timeout_d = hold_tmo && !done_i && owner_req;
                end else if (!hold_freeze && (hcnt_q != HCNT_LAST)) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign busy_o    = (state_q == OWN);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// tb/tb_rr_gate_arbiter.sv - randomized and directed checks of rr_gate_arbiter against a behavioural model
module tb_rr_gate_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic           done = 1'b0;
    logic           lock = 1'b0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index (-1 when idle), cycles owned so far, next scan start.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    rr_gate_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .done_i    (done),
        .lock_i    (lock),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presented now.
    task automatic model_step();
        bit frozen;
        bit tmo;
        int c;
        frozen = 1'b0;
`ifdef ARB_LOCK_EN
        frozen = lock;
`endif
        if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_held  = 1;
                    break;
                end
            end
        end else begin
            tmo = (m_held >= MAX_HOLD) && !frozen;
            if (done || !req[m_owner] || tmo) begin
                m_to    = tmo && !done && req[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_to = 1'b0;
                if (!frozen) m_held++;
            end
        end
    endtask

    task automatic compare_outputs();
        chk("gnt",     32'(gnt),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("gnt_id",  32'(gnt_id),  (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("busy",    32'(busy),    (m_owner < 0) ? 32'd0 : 32'd1);
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt",    32'(gnt),     32'd0);
        chk("rst_gnt_id", 32'(gnt_id),  32'd0);
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_tmo",    32'(timeout), 32'd0);
        model_reset();
        req  = '0;
        done = 1'b0;
        lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int tcnt;
        logic [N-1:0] seq_exp [10];

        #3;
        chk("init_gnt",  32'(gnt),  32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, DONE in its third owned cycle; then pointer has moved to 1.
        req = 4'b0001;
        step();
        chk("t1_first_gnt", 32'(gnt), 32'd1);
        n = (busy === 1'b1) ? 1 : 0;
        step(); if (busy === 1'b1) n++;
        step(); if (busy === 1'b1) n++;
        done = 1'b1;
        step(); if (busy === 1'b1) n++;
        chk("t1_busy_cycles", 32'(n), 32'd3);
        done = 1'b0;
        req  = 4'b1111;
        step();
        chk("t1_ptr_after", 32'(gnt), 32'b0010);
        do_reset();

        // All request, DONE always: 0,1,2,3,0 with a bubble between grants.
        seq_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                    4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        req  = 4'b1111;
        done = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t2_order", 32'(gnt), 32'(seq_exp[k]));
        end
        do_reset();

        // No DONE: held MAX_HOLD cycles, TIMEOUT on release, regrant after the bubble.
        req = 4'b0100;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (busy === 1'b1) n++;
            else break;
        end
        chk("t3_hold_len", 32'(n), 32'(MAX_HOLD));
        chk("t3_timeout", 32'(timeout), 32'd1);
        step();
        chk("t3_regrant", 32'(gnt), 32'b0100);
        chk("t3_tmo_clear", 32'(timeout), 32'd0);
        do_reset();

        // LOCK held for 20 cycles.
        req  = 4'b0010;
        lock = 1'b1;
        tcnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (timeout === 1'b1) tcnt++;
        end
`ifdef ARB_LOCK_EN
        chk("t4_lock_tmo", 32'(tcnt), 32'd0);
        chk("t4_lock_busy", 32'(busy), 32'd1);
`else
        chk("t4_nolock_tmo", 32'(tcnt), 32'd2);
`endif
        lock = 1'b0;
        do_reset();

        // Owner drops request: plain release; next scan starts after old owner.
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        chk("t5_drop_gnt", 32'(gnt), 32'd0);
        chk("t5_drop_tmo", 32'(timeout), 32'd0);
        req = 4'b1000;
        step();
        chk("t5_grant3", 32'(gnt), 32'b1000);

        // Mid-grant async reset, then lowest set request wins.
        req = 4'b0100;
        step();
        step();
        step();
        do_reset();
        req = 4'b1010;
        step();
        chk("t6_after_rst", 32'(gnt), 32'b0010);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            end
            done = ($urandom_range(5) == 0);
            lock = ($urandom_range(2) == 0);
            step();
            if (k == 1500) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
